// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings, FSM states, default latencies.
// Pure definitions, no logic; imported by e_mdu and e_mdu_calc.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational {hi,lo} result for mult/multu/div/divu plus a divide-by-zero flag.
// Zero latency; no flow control, the parent decides when the result is captured.
module e_mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero
);

  logic               sgn;
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    sgn      = (op == MDU_MULT) || (op == MDU_DIV);
    mul_a    = sgn ? {{WIDTH{rs_val[WIDTH-1]}}, rs_val} : {{WIDTH{1'b0}}, rs_val};
    mul_b    = sgn ? {{WIDTH{rt_val[WIDTH-1]}}, rt_val} : {{WIDTH{1'b0}}, rt_val};
    div_zero = is_div(op) && (rt_val == '0);
    // Signed divide runs on magnitudes; the most negative dividend maps to itself,
    // which is its correct unsigned magnitude, so overflow needs no special case.
    dvd = (sgn && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    if (rt_val == '0)
      dvs = WIDTH'(1);
    else
      dvs = (sgn && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    quo = dvd / dvs;
    rem = dvd % dvs;
    if (sgn && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]))
      quo = -quo;
    if (sgn && rs_val[WIDTH-1])
      rem = -rem;
    result = is_div(op) ? {rem, quo} : mul_a * mul_b;
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/div, immediate mthi/mtlo, HI/LO registers (MDU_CANCEL_EN adds cancel).
// Latency MULT_CYCLES / DIV_CYCLES edges from accept to commit; mthi/mtlo one edge.
// No backpressure: starts while busy are ignored except on the commit edge, where a new op may be accepted.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdu_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
`ifdef MDU_CANCEL_EN
  input  logic             cancel,
`endif
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  mdu_state_e         state;
  mdu_state_e         state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] calc_res;
  logic               calc_div_zero;
  logic [2*WIDTH-1:0] res_q;
  logic               div_zero_q;
  logic               flush;
  logic               done;
  logic               accept;
  logic               go_long;
  logic               go_mthi;
  logic               go_mtlo;

`ifdef MDU_CANCEL_EN
  assign flush = cancel;
`else
  assign flush = 1'b0;
`endif

  assign done    = (state == ST_BUSY) && (cnt == CW'(1)) && !flush;
  assign accept  = start && !flush && ((state == ST_IDLE) || done);
  assign go_long = accept && (is_mul(mdu_op) || is_div(mdu_op));
  assign go_mthi = accept && (mdu_op == MDU_MTHI);
  assign go_mtlo = accept && (mdu_op == MDU_MTLO);

  e_mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op       (mdu_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .result   (calc_res),
    .div_zero (calc_div_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (go_long) state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (flush)     state_nxt = ST_IDLE;
        else if (done) state_nxt = go_long ? ST_BUSY : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_BUSY);
  end

  // Result is captured at accept so forwarded operands need not be held during BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      res_q      <= '0;
      div_zero_q <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      if (go_long) begin
        cnt        <= is_mul(mdu_op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        res_q      <= calc_res;
        div_zero_q <= calc_div_zero;
      end else if (flush) begin
        cnt <= '0;
      end else if (state == ST_BUSY) begin
        cnt <= cnt - CW'(1);
      end
      if (done && !div_zero_q) begin
        hi <= res_q[2*WIDTH-1:WIDTH];
        lo <= res_q[WIDTH-1:0];
      end
      if (go_mthi) hi <= rs_val;
      if (go_mtlo) lo <= rs_val;
    end
  end

endmodule
